// File: rtl/seq_pkg.sv
// Shared types and index arithmetic for the step sequencer.
// Pure declarations; no latency, no flow control.
package seq_pkg;

  localparam int unsigned SEL_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SAMPLE = 2'd1,
    ST_OFFER  = 2'd2,
    ST_WAIT   = 2'd3
  } seq_state_t;

  // dir=1 counts down; both directions wrap within 0..num_steps-1.
  function automatic logic [SEL_W-1:0] next_idx(input logic [SEL_W-1:0] cur,
                                                input logic             dir,
                                                input int unsigned      num_steps);
    logic [SEL_W-1:0] last;
    last = SEL_W'(num_steps - 1);
    if (dir) begin
      return (cur == '0) ? last : cur - 1'b1;
    end
    return (cur == last) ? '0 : cur + 1'b1;
  endfunction

  function automatic logic idx_wraps(input logic [SEL_W-1:0] cur,
                                     input logic             dir,
                                     input int unsigned      num_steps);
    logic [SEL_W-1:0] last;
    last = SEL_W'(num_steps - 1);
    return dir ? (cur == '0) : (cur == last);
  endfunction

endpackage

// File: rtl/t_tick_prescaler.sv
// Step-rate prescaler: tick pulses combinationally on the TICK_DIV-th enabled cycle.
// Latency: tick in the same cycle the count reaches TICK_DIV-1; no backpressure, holds when disabled.
module t_tick_prescaler #(
  parameter int unsigned TICK_DIV = 50_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic clear,
  output logic tick
);

  localparam int unsigned CW = $clog2(TICK_DIV + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt;

  assign tick = enable && !clear && (cnt == CNT_MAX);

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable) begin
      if (cnt == CNT_MAX) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/t_step_seq.sv
// Step sequencer driving the byte-mux select and offering {step_idx, step_data} downstream.
// Latency: advance -> step_valid 2 cycles; period TICK_DIV+2. Offer held until step_ready; stalls add 1:1.
// Option: define SEQ_REVERSE_EN to add the dir port (1 = count down).
module t_step_seq
  import seq_pkg::*;
#(
  parameter int unsigned NUM_STEPS = 12,
  parameter int unsigned TICK_DIV  = 50_000_000,
  parameter int unsigned DW        = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic             restart,
  output logic [SEL_W-1:0] sel,
  input  logic [DW-1:0]    mux_y,
  output logic [DW-1:0]    step_data,
  output logic [SEL_W-1:0] step_idx,
  output logic             step_valid,
  input  logic             step_ready,
  output logic             seq_wrap
`ifdef SEQ_REVERSE_EN
  ,
  input  logic             dir
`endif
);

  seq_state_t       state, state_nxt;
  logic [SEL_W-1:0] cur;
  logic             restart_pend;
  logic             tick;
  logic             psc_en, psc_clr;
  logic             do_restart, do_advance, do_capture;
  logic             adv_dir;

`ifdef SEQ_REVERSE_EN
  assign adv_dir = dir;
`else
  assign adv_dir = 1'b0;
`endif

  assign sel        = cur;
  assign step_valid = (state == ST_OFFER);

  // Restart has priority over the tick, so it also masks the counter.
  assign psc_en  = (state == ST_WAIT) && run && !restart;
  assign psc_clr = restart || ((state == ST_WAIT) && !run);

  t_tick_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_prescaler (
    .clk    (clk),
    .reset  (reset),
    .enable (psc_en),
    .clear  (psc_clr),
    .tick   (tick)
  );

  always_comb begin
    state_nxt  = state;
    do_restart = 1'b0;
    do_advance = 1'b0;
    do_capture = 1'b0;
    case (state)
      ST_IDLE: begin
        if (restart) begin
          do_restart = 1'b1;
          state_nxt  = run ? ST_SAMPLE : ST_IDLE;
        end else if (run) begin
          state_nxt = ST_SAMPLE;
        end
      end
      ST_SAMPLE: begin
        if (restart) begin
          do_restart = 1'b1;
          state_nxt  = run ? ST_SAMPLE : ST_IDLE;
        end else begin
          do_capture = 1'b1;
          state_nxt  = ST_OFFER;
        end
      end
      ST_OFFER: begin
        // A restart seen while offering is deferred until the consumer takes the step.
        if (step_ready) begin
          if (restart_pend || restart) begin
            do_restart = 1'b1;
            state_nxt  = run ? ST_SAMPLE : ST_IDLE;
          end else begin
            state_nxt = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (restart) begin
          do_restart = 1'b1;
          state_nxt  = run ? ST_SAMPLE : ST_IDLE;
        end else if (!run) begin
          state_nxt = ST_IDLE;
        end else if (tick) begin
          do_advance = 1'b1;
          state_nxt  = ST_SAMPLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_IDLE;
      cur          <= '0;
      restart_pend <= 1'b0;
      step_data    <= '0;
      step_idx     <= '0;
      seq_wrap     <= 1'b0;
    end else begin
      state    <= state_nxt;
      seq_wrap <= 1'b0;
      if (do_restart) begin
        cur <= '0;
      end else if (do_advance) begin
        cur      <= next_idx(cur, adv_dir, NUM_STEPS);
        seq_wrap <= idx_wraps(cur, adv_dir, NUM_STEPS);
      end
      if (state == ST_OFFER && step_ready) begin
        restart_pend <= 1'b0;
      end else if (state == ST_OFFER && restart) begin
        restart_pend <= 1'b1;
      end
      if (do_capture) begin
        step_data <= mux_y;
        step_idx  <= cur;
      end
    end
  end

endmodule

// File: tb/tb_t_step_seq.sv
// Bench for t_step_seq with NUM_STEPS=12, TICK_DIV=4 and a mux returning 8'h10+sel.
module tb_t_step_seq;
  import seq_pkg::*;

  logic             clk = 1'b0;
  logic             reset, run, restart, step_ready;
  logic [SEL_W-1:0] sel, step_idx;
  logic [7:0]       mux_y, step_data;
  logic             step_valid, seq_wrap;
`ifdef SEQ_REVERSE_EN
  logic             dir = 1'b0;
`endif

  always #5 clk = ~clk;

  assign mux_y = 8'h10 + {4'd0, sel};

  t_step_seq #(.NUM_STEPS(12), .TICK_DIV(4), .DW(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .run        (run),
    .restart    (restart),
    .sel        (sel),
    .mux_y      (mux_y),
    .step_data  (step_data),
    .step_idx   (step_idx),
    .step_valid (step_valid),
    .step_ready (step_ready),
    .seq_wrap   (seq_wrap)
`ifdef SEQ_REVERSE_EN
    ,
    .dir        (dir)
`endif
  );

  typedef struct {
    logic [3:0] idx;
    int         gap;
    int         wraps;
  } vec_t;

  typedef struct {
    logic [3:0] idx;
    logic [7:0] data;
  } offer_t;

  int     total = 0;
  int     bad = 0;
  int     cyc = 0;
  int     last_hs = 0;
  int     wrap_cnt = 0;
  int     wrap_base = 0;
  logic [3:0] prev_sel = '0;
  offer_t sb[$];
  vec_t   tbl[17];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc++;

  // A wrap pulse must coincide with sel crossing the sequence boundary.
  always @(negedge clk) begin
    if (!reset && seq_wrap) begin
      wrap_cnt++;
      check("wrap_edge",
            32'(({prev_sel, sel} == {4'd11, 4'd0}) || ({prev_sel, sel} == {4'd0, 4'd11})), 32'd1);
    end
    prev_sel = sel;
  end

  task automatic expect_offer(input logic [3:0] idx);
    offer_t o;
    o.idx  = idx;
    o.data = 8'h10 + {4'd0, idx};
    sb.push_back(o);
  endtask

  // Waits for the handshake, compares against the scoreboard, leaves us just past the handshake edge.
  task automatic do_offer(input logic [3:0] idx, input int gap, input int wraps);
    bit     ok;
    offer_t e;
    expect_offer(idx);
    ok = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (step_valid && step_ready) begin
        ok = 1;
        break;
      end
    end
    e = sb.pop_front();
    if (!ok) begin
      check("hs_timeout", 32'd0, 32'd1);
    end else begin
      check("offer_idx", 32'(step_idx), 32'(e.idx));
      check("offer_data", 32'(step_data), 32'(e.data));
      if (gap > 0) check("offer_gap", 32'(cyc - last_hs), 32'(gap));
      check("offer_wraps", 32'(wrap_cnt - wrap_base), 32'(wraps));
    end
    last_hs   = cyc;
    wrap_base = wrap_cnt;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(output bit ok);
    ok = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (step_valid) begin
        ok = 1;
        break;
      end
    end
    if (!ok) check("valid_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    bit ok;
    int k;
    for (int i = 0; i < 17; i++) begin
      tbl[i].idx   = 4'(i % 12);
      tbl[i].gap   = (i == 0) ? -1 : 6;
      tbl[i].wraps = (i == 12) ? 1 : 0;
    end

    reset = 1'b1; run = 1'b1; restart = 1'b0; step_ready = 1'b1;
    @(posedge clk);
    repeat (3) begin
      @(negedge clk);
      check("rst_valid", 32'(step_valid), 32'd0);
      check("rst_sel", 32'(sel), 32'd0);
      check("rst_idx", 32'(step_idx), 32'd0);
      check("rst_data", 32'(step_data), 32'd0);
      check("rst_wrap", 32'(seq_wrap), 32'd0);
    end
    @(posedge clk);
    #1 reset = 1'b0;

    // Free-running walk through a full wrap and on to step 4.
    for (int i = 0; i < 17; i++) do_offer(tbl[i].idx, tbl[i].gap, tbl[i].wraps);

    // Consumer stall on step 5.
    step_ready = 1'b0;
    expect_offer(4'd5);
    wait_valid(ok);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check("stall_valid", 32'(step_valid), 32'd1);
      check("stall_idx", 32'(step_idx), 32'(sb[0].idx));
      check("stall_data", 32'(step_data), 32'(sb[0].data));
      check("stall_sel", 32'(sel), 32'd5);
    end
    @(posedge clk);
    #1 step_ready = 1'b1;
    void'(sb.pop_front());
    do_offer(4'd5, -1, 0);
    k = 0;
    while (k < 20) begin
      @(posedge clk);
      @(negedge clk);
      k++;
      if (sel == 4'd6) break;
    end
    check("advance_after_hs", 32'(k), 32'd4);
    do_offer(4'd6, -1, 0);

    // Restart during the offer of step 7 is deferred to its handshake.
    step_ready = 1'b0;
    wait_valid(ok);
    check("pre_restart_idx", 32'(step_idx), 32'd7);
    @(posedge clk);
    #1 restart = 1'b1;
    @(posedge clk);
    #1 restart = 1'b0;
    @(posedge clk);
    #1 step_ready = 1'b1;
    do_offer(4'd7, -1, 0);
    do_offer(4'd0, 2, 0);

    // run drops mid-WAIT after step 3; the step is re-offered on resume.
    do_offer(4'd1, 6, 0);
    do_offer(4'd2, 6, 0);
    do_offer(4'd3, 6, 0);
    @(posedge clk);
    #1 run = 1'b0;
    repeat (20) begin
      @(negedge clk);
      check("hold_valid", 32'(step_valid), 32'd0);
      check("hold_sel", 32'(sel), 32'd3);
    end
    @(posedge clk);
    #1 run = 1'b1;
    do_offer(4'd3, -1, 0);
    do_offer(4'd4, 6, 0);

`ifdef SEQ_REVERSE_EN
    restart = 1'b1;
    dir     = 1'b1;
    @(posedge clk);
    #1 restart = 1'b0;
    do_offer(4'd0, -1, 0);
    do_offer(4'd11, 6, 1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
